// File: rtl/nn_pkg.sv
// Shared constants, FSM state codes and the issue-flag bundle for the layer sequencer.
// Optional feature macro: NN_BIAS_EN (adds one bias term per neuron).
package nn_pkg;

  localparam int N_IN  = 10;
  localparam int N_HID = 5;
  localparam int N_OUT = 3;
  localparam int AW    = 7;
  localparam int IW    = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HID_MAC = 3'd1;
  localparam logic [2:0] ST_HID_WB  = 3'd2;
  localparam logic [2:0] ST_OUT_MAC = 3'd3;
  localparam logic [2:0] ST_OUT_WB  = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int S_H_BIAS      = N_IN + 1;
  localparam int S_O_BIAS      = N_HID + 1;
  localparam int OUT_BASE_BIAS = N_HID * S_H_BIAS;
  localparam int S_H_NOBIAS      = N_IN;
  localparam int S_O_NOBIAS      = N_HID;
  localparam int OUT_BASE_NOBIAS = N_HID * S_H_NOBIAS;

`ifdef NN_BIAS_EN
  localparam int S_H      = S_H_BIAS;
  localparam int S_O      = S_O_BIAS;
  localparam int OUT_BASE = OUT_BASE_BIAS;
`else
  localparam int S_H      = S_H_NOBIAS;
  localparam int S_O      = S_O_NOBIAS;
  localparam int OUT_BASE = OUT_BASE_NOBIAS;
`endif

  localparam int MAX_ADDR = OUT_BASE + N_OUT * S_O - 1;

  typedef struct packed {
    logic          mac_en;
    logic          mac_clr;
    logic          mac_bias;
    logic          mac_layer;
    logic [IW-1:0] mac_sel;
    logic          wb_en;
    logic          wb_layer;
    logic [IW-1:0] wb_idx;
  } seq_flags_t;

endpackage

// File: rtl/nn_seq_pipe.sv
// One-stage delay for the MAC/write-back flag bundle so it lines up with ROM read data.
module nn_seq_pipe
  import nn_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  seq_flags_t i_d,
  output seq_flags_t o_q
);

  seq_flags_t r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/nn_layer_seq.sv
// Steps the shared MAC through all hidden then all output neurons, driving ROM address and flags.
// Optional feature macro: NN_BIAS_EN (bias term at the end of each neuron's term list).
module nn_layer_seq
  import nn_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_addr,
  output logic          o_mac_en,
  output logic          o_mac_clr,
  output logic          o_mac_bias,
  output logic          o_mac_layer,
  output logic [IW-1:0] o_mac_sel,
  output logic          o_wb_en,
  output logic          o_wb_layer,
  output logic [IW-1:0] o_wb_idx
);

  logic [2:0]    r_state;
  logic [IW-1:0] r_neuron;
  logic [IW-1:0] r_term;
  seq_flags_t    w_issue;
  seq_flags_t    w_flags;
  logic [AW-1:0] w_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_neuron <= '0;
      r_term   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state  <= ST_HID_MAC;
          r_neuron <= '0;
          r_term   <= '0;
        end
        ST_HID_MAC: if (r_term == IW'(S_H - 1)) begin
          r_state <= ST_HID_WB;
          r_term  <= '0;
        end else r_term <= r_term + 1'b1;
        ST_HID_WB: if (r_neuron == IW'(N_HID - 1)) begin
          r_state  <= ST_OUT_MAC;
          r_neuron <= '0;
        end else begin
          r_state  <= ST_HID_MAC;
          r_neuron <= r_neuron + 1'b1;
        end
        ST_OUT_MAC: if (r_term == IW'(S_O - 1)) begin
          r_state <= ST_OUT_WB;
          r_term  <= '0;
        end else r_term <= r_term + 1'b1;
        ST_OUT_WB: if (r_neuron == IW'(N_OUT - 1)) begin
          r_state  <= ST_DRAIN;
          r_neuron <= '0;
        end else begin
          r_state  <= ST_OUT_MAC;
          r_neuron <= r_neuron + 1'b1;
        end
        ST_DRAIN: r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue stage: address goes straight to the ROM, flags wait one cycle for its data.
  always_comb begin
    w_issue = '0;
    w_addr  = '0;
    case (r_state)
      ST_HID_MAC: begin
        w_issue.mac_en  = 1'b1;
        w_issue.mac_clr = (r_term == '0);
        w_issue.mac_sel = r_term;
`ifdef NN_BIAS_EN
        w_issue.mac_bias = (r_term == IW'(S_H - 1));
`endif
        w_addr = AW'(r_neuron) * AW'(S_H) + AW'(r_term);
      end
      ST_OUT_MAC: begin
        w_issue.mac_en    = 1'b1;
        w_issue.mac_clr   = (r_term == '0);
        w_issue.mac_layer = 1'b1;
        w_issue.mac_sel   = r_term;
`ifdef NN_BIAS_EN
        w_issue.mac_bias = (r_term == IW'(S_O - 1));
`endif
        w_addr = AW'(OUT_BASE) + AW'(r_neuron) * AW'(S_O) + AW'(r_term);
      end
      ST_HID_WB: begin
        w_issue.wb_en  = 1'b1;
        w_issue.wb_idx = r_neuron;
      end
      ST_OUT_WB: begin
        w_issue.wb_en    = 1'b1;
        w_issue.wb_layer = 1'b1;
        w_issue.wb_idx   = r_neuron;
      end
      default: ;
    endcase
  end

  nn_seq_pipe u_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (w_issue),
    .o_q   (w_flags)
  );

  assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done      = (r_state == ST_DONE);
  assign o_addr      = w_addr;
  assign o_mac_en    = w_flags.mac_en;
  assign o_mac_clr   = w_flags.mac_clr;
  assign o_mac_bias  = w_flags.mac_bias;
  assign o_mac_layer = w_flags.mac_layer;
  assign o_mac_sel   = w_flags.mac_sel;
  assign o_wb_en     = w_flags.wb_en;
  assign o_wb_layer  = w_flags.wb_layer;
  assign o_wb_idx    = w_flags.wb_idx;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: closed-form timeline model plus ROM/accumulator model, random start/reset.
module tb_nn_layer_seq;

  localparam int NI = 10, NH = 5, NO = 3;
`ifdef NN_BIAS_EN
  localparam int SH = NI + 1, SO = NH + 1, BIAS = 1;
  localparam int LIT_DONE = 83, LIT_MAX = 72, LIT_OBASE = 55, LIT_BIASN = 8;
  localparam int LIT_WB1 = 13, LIT_HRES = 11, LIT_ORES = 56;
`else
  localparam int SH = NI, SO = NH, BIAS = 0;
  localparam int LIT_DONE = 75, LIT_MAX = 64, LIT_OBASE = 50, LIT_BIASN = 0;
  localparam int LIT_WB1 = 12, LIT_HRES = 10, LIT_ORES = 50;
`endif
  localparam int OBASE = NH * SH;
  localparam int HLEN  = NH * (SH + 1);
  localparam int OLEN  = NO * (SO + 1);
  localparam int TDONE = HLEN + OLEN + 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, mac_en, mac_clr, mac_bias, mac_layer, wb_en, wb_layer;
  logic [6:0] addr;
  logic [3:0] mac_sel, wb_idx;

  int checks = 0, errors = 0;
  int m_t = 0;
  bit chk_on = 1'b0;
  int acc = 0;
  int hid_res[NH];
  int out_res[NO];

  nn_layer_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_addr(addr),
    .o_mac_en(mac_en), .o_mac_clr(mac_clr), .o_mac_bias(mac_bias),
    .o_mac_layer(mac_layer), .o_mac_sel(mac_sel),
    .o_wb_en(wb_en), .o_wb_layer(wb_layer), .o_wb_idx(wb_idx)
  );

  always #5 clk = ~clk;

  // What the sequencer issues in pass cycle t (t=1 is the first address cycle).
  function automatic void issue(input int t, output logic [6:0] a, output logic en, output logic clr,
                                output logic bs, output logic lay, output logic [3:0] sel,
                                output logic wb, output logic wbl, output logic [3:0] wbi);
    int n, r;
    a = '0; en = 0; clr = 0; bs = 0; lay = 0; sel = '0; wb = 0; wbl = 0; wbi = '0;
    if (t >= 1 && t <= HLEN) begin
      n = (t - 1) / (SH + 1); r = (t - 1) % (SH + 1);
      if (r < SH) begin
        a = 7'(n * SH + r); en = 1; clr = (r == 0); bs = (BIAS == 1) && (r == SH - 1); sel = 4'(r);
      end else begin
        wb = 1; wbi = 4'(n);
      end
    end else if (t > HLEN && t <= HLEN + OLEN) begin
      n = (t - HLEN - 1) / (SO + 1); r = (t - HLEN - 1) % (SO + 1);
      if (r < SO) begin
        a = 7'(OBASE + n * SO + r); en = 1; clr = (r == 0); bs = (BIAS == 1) && (r == SO - 1);
        lay = 1; sel = 4'(r);
      end else begin
        wb = 1; wbl = 1; wbi = 4'(n);
      end
    end
  endfunction

  function automatic logic [22:0] expv(input int t);
    logic [6:0] a, a0;
    logic en, clr, bs, lay, wb, wbl, e0, c0, b0, l0, w0, wl0;
    logic [3:0] sel, wbi, s0, wi0;
    issue(t, a, e0, c0, b0, l0, s0, w0, wl0, wi0);
    issue(t - 1, a0, en, clr, bs, lay, sel, wb, wbl, wbi);
    return {(t >= 1 && t <= TDONE - 1), (t == TDONE), a, en, clr, bs, lay, sel, wb, wbl, wbi};
  endfunction

  function automatic logic [22:0] actv();
    return {busy, done, addr, mac_en, mac_clr, mac_bias, mac_layer, mac_sel, wb_en, wb_layer, wb_idx};
  endfunction

  // Pass-position model: IDLE is 0, DONE is TDONE, start only honoured in IDLE.
  always @(posedge clk) begin
    if (rst)              m_t = 0;
    else if (m_t == 0)    m_t = start ? 1 : 0;
    else if (m_t >= TDONE) m_t = 0;
    else                  m_t = m_t + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [22:0] e, a;
      int op;
      e = expv(m_t);
      a = actv();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0d actual=%h required=%h", m_t, a, e);
      end
      if (wb_en) begin
        if (wb_layer) begin if (wb_idx < NO) out_res[wb_idx] = acc; end
        else if (wb_idx < NH) hid_res[wb_idx] = acc;
      end
      if (mac_en) begin
        op = mac_bias ? 1 : (!mac_layer ? 1 : (mac_sel < NH ? hid_res[mac_sel] : 0));
        acc = mac_clr ? op : acc + op;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic observe_pass(input string tag);
    int done_t = -1, busy_n = 0, maxa = 0, bias_n = 0, wb_n = 0, wb1_t = -1, ob = -1;
    for (int i = 0; i < NH; i++) hid_res[i] = -1;
    for (int i = 0; i < NO; i++) out_res[i] = -1;
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    for (int t = 1; t <= TDONE + 1; t++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && done_t < 0) done_t = t;
      if (int'(addr) > maxa) maxa = int'(addr);
      if (mac_bias) bias_n++;
      if (wb_en) begin wb_n++; if (wb1_t < 0) wb1_t = t; end
      if (t == HLEN + 1) ob = int'(addr);
    end
    chk({tag, "_done_cycle"}, done_t, LIT_DONE);
    chk({tag, "_busy_cycles"}, busy_n, LIT_DONE - 1);
    chk({tag, "_max_addr"}, maxa, LIT_MAX);
    chk({tag, "_bias_count"}, bias_n, LIT_BIASN);
    chk({tag, "_out_base"}, ob, LIT_OBASE);
    chk({tag, "_wb_count"}, wb_n, NH + NO);
    chk({tag, "_first_wb"}, wb1_t, LIT_WB1);
    for (int i = 0; i < NH; i++) chk({tag, "_hid_res"}, hid_res[i], LIT_HRES);
    for (int i = 0; i < NO; i++) chk({tag, "_out_res"}, out_res[i], LIT_ORES);
  endtask

  initial begin
    int dn, d1, d2;
    @(posedge clk); chk_on = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("reset_zero", int'(actv()), 0);

    observe_pass("p1");

    // start held high: back-to-back passes, one every TDONE+1 cycles
    dn = 0; d1 = -1; d2 = -1;
    @(posedge clk); #2 start = 1;
    @(posedge clk);
    for (int t = 1; t <= 3 * (TDONE + 1); t++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (d1 < 0) d1 = t; else if (d2 < 0) d2 = t;
      end
    end
    start = 0;
    chk("b2b_done_count", dn, 3);
    chk("b2b_period", d2 - d1, LIT_DONE + 1);
    repeat (4) @(posedge clk);

    // reset in the middle of the hidden phase
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    for (int t = 1; t <= 30; t++) @(negedge clk);
    rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("mid_reset_zero", int'(actv()), 0);
    observe_pass("p2");

    // random start pulses and occasional resets, checked by the timeline model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #2 start = 0; rst = 0;
    repeat (TDONE + 4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
